mcht_tx_sched: RTL
==================

Name: mcht_tx_sched

Overview:
- Round-robin scheduler that shares the single Manchester transmitter (MCHT_TRX TX path) between pNUM_REQ requesters.
- Captures the winner's message and issues a one-cycle TX_VLD launch pulse, then waits for TX_DNE, with a timeout.
- Returns ACK or ERR to the winner and enforces an inter-frame gap before the next grant.
- Sits between the frame sources (host loader, BIST generator, etc.) and MCHT_TRX in the CLK_25M domain.

Parameters:
- pNUM_REQ, 4, number of requesters (2..8).
- pMSG_LEN, 8, message width; must match MCHT_TRX pTX_MSG_LEN.
- pIFG_CYC, 4, inter-frame gap in CLK_25M cycles (1..255).
- pTMO_CYC, 1023, CLK_25M cycles to wait for TX_DNE before declaring timeout (2..65535).

Ports:
- CLK_25M  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- REQ  in  pNUM_REQ  per-requester transmit request, level.
- REQ_MSG  in  pNUM_REQ*pMSG_LEN  flattened messages; requester i uses bits [i*pMSG_LEN +: pMSG_LEN].
- HALT  in  1  blocks new grants; the frame in flight completes.
- GNT  out  pNUM_REQ  one-hot grant, held from launch until completion.
- ACK  out  pNUM_REQ  one-cycle completion pulse to the winner.
- ERR  out  pNUM_REQ  one-cycle timeout pulse to the winner.
- TX_VLD  out  1  one-cycle launch pulse to MCHT_TRX.
- TX_MSG  out  pMSG_LEN  message to MCHT_TRX; stable from launch until the next launch.
- TX_DNE  in  1  transmit-done pulse from MCHT_TRX.
- BUSY  out  1  high in any state other than IDLE.
- TMO_CNT  out  8  saturating count of timeouts since reset.

Behaviour:
- Clock and reset: single clock CLK_25M; reset RST is synchronous and active-high.
- Reset, taken on any edge with RST=1, including mid-frame:
  - state=IDLE.
  - GNT, ACK, ERR, TX_VLD, BUSY = 0.
  - TX_MSG=0, TMO_CNT=0, timers=0.
  - last-winner pointer = pNUM_REQ-1, so requester 0 has first priority.
- States: IDLE, WAIT, GAP.
- IDLE:
  - Transition fires when (|REQ) & !HALT at edge k.
  - Winner w = first i with REQ[i]=1, scanning (ptr+1, ptr+2, ... mod pNUM_REQ).
  - After edge k: GNT[w]=1, TX_MSG=REQ_MSG[w] (captured at edge k), TX_VLD=1 for exactly one cycle, ptr=w, timer=0, state=WAIT.
  - Latency from REQ sampled to TX_VLD high: 1 cycle.
- WAIT:
  - Timer increments each cycle.
  - TX_DNE=1: after the edge, ACK[w]=1 for one cycle, GNT=0, state=GAP.
  - Else, if timer reaches pTMO_CYC-1: after the edge, ERR[w]=1 for one cycle, GNT=0, TMO_CNT+1 (saturates at 255), state=GAP.
  - TX_DNE and timeout in the same cycle: TX_DNE wins; ACK only, no ERR.
  - REQ or HALT changes during WAIT do not abort the frame.
- GAP:
  - Stays exactly pIFG_CYC cycles, then IDLE.
  - No grant is possible during GAP.
  - BUSY stays high.
- TX_DNE outside WAIT: ignored, no pulse, no state change.
- Requester contract:
  - Hold REQ until ACK or ERR.
  - REQ still high after ACK is a new request and competes in the next IDLE.
  - Under continuous contention, every requester is served within pNUM_REQ frames.
- Output invariants:
  - ACK and ERR are never both set.
  - At most one GNT bit is set.
  - ACK and ERR only ever appear on the granted index.
- HALT rises while in IDLE with REQ pending: no grant; the grant proceeds on the first IDLE cycle with HALT=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Single request: REQ=4'b0001, REQ_MSG[7:0]=8'hA5, TX_DNE pulsed 20 cycles after TX_VLD.
  - Required: TX_VLD one cycle after REQ sampled, TX_MSG=8'hA5, GNT=4'b0001 throughout WAIT.
  - Required: ACK[0] one cycle after TX_DNE, then BUSY high for 4 GAP cycles, then IDLE.
- Round-robin: REQ=4'b1111 held, TX_DNE returned each frame.
  - Required: grant order 0,1,2,3,0.
  - Required: 5 ACKs total, each on the matching index.
  - Required: no two frames closer than pIFG_CYC+2 cycles launch-to-launch.
- Timeout: REQ=4'b0100, TX_DNE never asserted.
  - Required: ERR[2] exactly pTMO_CYC cycles after TX_VLD, no ACK, TMO_CNT=1.
  - Repeat 300 times: TMO_CNT saturates at 255.
- Collision and stray done:
  - TX_DNE asserted on the exact timeout cycle -> ACK only, TMO_CNT unchanged.
  - TX_DNE pulsed in IDLE and GAP -> no ACK, no state change.
- HALT: HALT=1 with REQ=4'b0010 -> no TX_VLD for 50 cycles; drop HALT -> TX_VLD next cycle.
  - HALT raised during WAIT -> frame still completes with ACK.
- Reset mid-operation: RST=1 for one cycle in WAIT.
  - Required: next cycle all outputs 0, state IDLE.
  - Required: with REQ=4'b1010 held, first grant goes to requester 1 (ptr reset).

Source files
------------

// File: rtl/mcht_tx_sched.sv
// Round-robin arbiter sharing one Manchester TX path between pNUM_REQ frame sources.
// Launches the winner's message, waits for TX_DNE or timeout, then holds an inter-frame gap.
module mcht_tx_sched #(
  parameter int pNUM_REQ = 4,
  parameter int pMSG_LEN = 8,
  parameter int pIFG_CYC = 4,
  parameter int pTMO_CYC = 1023
) (
  input  logic                         CLK_25M,
  input  logic                         RST,
  input  logic [pNUM_REQ-1:0]          REQ,
  input  logic [pNUM_REQ*pMSG_LEN-1:0] REQ_MSG,
  input  logic                         HALT,
  output logic [pNUM_REQ-1:0]          GNT,
  output logic [pNUM_REQ-1:0]          ACK,
  output logic [pNUM_REQ-1:0]          ERR,
  output logic                         TX_VLD,
  output logic [pMSG_LEN-1:0]          TX_MSG,
  input  logic                         TX_DNE,
  output logic                         BUSY,
  output logic [7:0]                   TMO_CNT,
  output logic [1:0]                   dbg_state
);

  localparam int PTR_W = $clog2(pNUM_REQ);
  localparam logic [15:0] TMO_LAST = 16'(pTMO_CYC - 1);
  localparam logic [7:0]  GAP_LAST = 8'(pIFG_CYC - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_GAP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, win_idx;
  logic                win_found;
  logic [15:0]         tmr_q;
  logic [7:0]          gap_q;
  logic                launch, done_ok, done_tmo, gap_end;
  logic [pNUM_REQ-1:0] gnt_d, ack_d, err_d;
  logic [pMSG_LEN-1:0] tx_msg_d;
  logic [7:0]          tmo_cnt_d;
  logic                tx_vld_d, busy_d;

  // Scan starts just after the last winner so every requester is reached within pNUM_REQ frames.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int off = 1; off <= pNUM_REQ; off++) begin
      if (!win_found && REQ[(int'(ptr_q) + off) % pNUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr_q) + off) % pNUM_REQ);
      end
    end
  end

  assign launch   = (state_q == S_IDLE) && win_found && !HALT;
  assign done_ok  = (state_q == S_WAIT) && TX_DNE;
  assign done_tmo = (state_q == S_WAIT) && !TX_DNE && (tmr_q == TMO_LAST);
  assign gap_end  = (state_q == S_GAP) && (gap_q == GAP_LAST);

  // State register plus all registered outputs.
  always_ff @(posedge CLK_25M) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_W'(pNUM_REQ - 1);
      tmr_q   <= '0;
      gap_q   <= '0;
      GNT     <= '0;
      ACK     <= '0;
      ERR     <= '0;
      TX_VLD  <= 1'b0;
      TX_MSG  <= '0;
      BUSY    <= 1'b0;
      TMO_CNT <= '0;
    end else begin
      state_q <= state_d;
      if (launch) ptr_q <= win_idx;
      if (launch) tmr_q <= '0;
      else if (state_q == S_WAIT) tmr_q <= tmr_q + 16'd1;
      gap_q   <= (state_q == S_GAP) ? gap_q + 8'd1 : 8'd0;
      GNT     <= gnt_d;
      ACK     <= ack_d;
      ERR     <= err_d;
      TX_VLD  <= tx_vld_d;
      TX_MSG  <= tx_msg_d;
      BUSY    <= busy_d;
      TMO_CNT <= tmo_cnt_d;
    end
  end

  // Next-state logic; TX_DNE outside WAIT has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_WAIT;
      S_WAIT:  if (done_ok || done_tmo) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; ACK/ERR are taken from the held grant so they always hit the winner.
  always_comb begin
    gnt_d     = GNT;
    ack_d     = '0;
    err_d     = '0;
    tx_vld_d  = launch;
    tx_msg_d  = TX_MSG;
    tmo_cnt_d = TMO_CNT;
    busy_d    = (state_d != S_IDLE);
    if (launch) begin
      gnt_d          = '0;
      gnt_d[win_idx] = 1'b1;
      tx_msg_d       = REQ_MSG[int'(win_idx)*pMSG_LEN +: pMSG_LEN];
    end
    if (done_ok) begin
      ack_d = GNT;
      gnt_d = '0;
    end
    if (done_tmo) begin
      err_d = GNT;
      gnt_d = '0;
      if (TMO_CNT != 8'hFF) tmo_cnt_d = TMO_CNT + 8'd1;
    end
  end

  assign dbg_state = state_q;

endmodule
